ifid_skid_reg: RTL



---
 rtl/pipe_pkg.sv | 9 +
 rtl/stage_stall_counter.sv | 17 +
 rtl/ifid_skid_reg.sv | 79 +++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared occupancy encoding and default bubble payload for pipeline boundary registers
package pipe_pkg;
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;
  localparam logic [31:0] NOP_INS_DEF = 32'h0000_0000;
endpackage

// File: rtl/stage_stall_counter.sv
// stage_stall_counter: saturating event counter, cleared only by reset
module stage_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  assign cnt_o = cnt_q;
  // count up on each flagged cycle, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/ifid_skid_reg.sv
// ifid_skid_reg: IF/ID boundary register with two-entry skid buffer, hold/flush and stall counter
module ifid_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                PC_W    = 30,
  parameter logic [DATA_W-1:0] NOP_INS = DATA_W'(NOP_INS_DEF),
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_ins,
  input  logic              hold,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_ins,
  output logic [CNT_W-1:0]  stall_cnt
);
  occ_e              state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [PC_W-1:0]   head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
  logic [DATA_W-1:0] head_ins_q, head_ins_d, skid_ins_q, skid_ins_d;
  logic              enq, deq, load_head_in, load_head_skid, load_skid;

  assign out_valid = state_q != OCC_EMPTY;
  assign enq       = in_valid & in_ready_q & ~flush;
  assign deq       = out_valid & out_ready & ~hold & ~flush;
  // head takes the incoming beat when empty or when it is being replaced in the same cycle
  assign load_head_in   = enq & ((state_q == OCC_EMPTY) | deq);
  assign load_head_skid = deq & (state_q == OCC_FULL);
  assign load_skid      = enq & ~deq & (state_q == OCC_ONE);

  // occupancy and data steering; flush empties the buffer but leaves payload registers alone
  always_comb begin
    state_d    = flush ? OCC_EMPTY :
                 (state_q == OCC_EMPTY) ? (enq ? OCC_ONE : OCC_EMPTY) :
                 (state_q == OCC_ONE)   ? ((enq & ~deq) ? OCC_FULL : (deq & ~enq) ? OCC_EMPTY : OCC_ONE) :
                 (deq ? OCC_ONE : OCC_FULL);
    in_ready_d = state_d != OCC_FULL;
    head_pc_d  = load_head_in ? in_pc  : load_head_skid ? skid_pc_q  : head_pc_q;
    head_ins_d = load_head_in ? in_ins : load_head_skid ? skid_ins_q : head_ins_q;
    skid_pc_d  = load_skid ? in_pc  : skid_pc_q;
    skid_ins_d = load_skid ? in_ins : skid_ins_q;
  end

  // state, ready flag and entry registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= OCC_EMPTY;
      in_ready_q <= 1'b1;
      head_pc_q  <= '0;
      head_ins_q <= NOP_INS;
      skid_pc_q  <= '0;
      skid_ins_q <= NOP_INS;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_pc_q  <= head_pc_d;
      head_ins_q <= head_ins_d;
      skid_pc_q  <= skid_pc_d;
      skid_ins_q <= skid_ins_d;
    end

  assign in_ready = in_ready_q;
  assign out_pc   = head_pc_q;
  assign out_ins  = out_valid ? head_ins_q : NOP_INS;

  stage_stall_counter #(.CNT_W(CNT_W)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (out_valid & (hold | ~out_ready) & ~flush),
    .cnt_o (stall_cnt)
  );
endmodule
